// File: rtl/traffic_light_monitor.sv
// Passive lamp-side checker for the traffic_light controller: decodes the phase,
// checks safety, sequence and per-phase dwell (in ticks), and keeps sticky error state.
module traffic_light_monitor #(
  parameter int NS_G_TICKS = 5,
  parameter int NS_Y_TICKS = 2,
  parameter int EW_G_TICKS = 5,
  parameter int EW_Y_TICKS = 2,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        ns_g,
  input  logic        ns_y,
  input  logic        ns_r,
  input  logic        ew_g,
  input  logic        ew_y,
  input  logic        ew_r,
  output logic [1:0]  phase,
  output logic        phase_valid,
  output logic        err_conflict,
  output logic        err_lamp,
  output logic        err_seq,
  output logic        err_dwell,
  output logic        err_any,
  output logic [2:0]  first_err,
  output logic [7:0]  err_count,
  output logic [15:0] cycles_done
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  localparam logic [1:0] PH_NS_G = 2'd0;
  localparam logic [1:0] PH_NS_Y = 2'd1;
  localparam logic [1:0] PH_EW_G = 2'd2;
  localparam logic [1:0] PH_EW_Y = 2'd3;

  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  // Input sample stage; smp_vld_q masks the all-zero sample left by reset.
  logic [5:0] smp_lamps_q, smp_lamps_d;
  logic       smp_tick_q, smp_tick_d;
  logic       smp_vld_q, smp_vld_d;

  logic [0:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             dflag_q, dflag_d;
  logic             phase_valid_q, phase_valid_d;
  logic             err_conflict_q, err_conflict_d;
  logic             err_lamp_q, err_lamp_d;
  logic             err_seq_q, err_seq_d;
  logic             err_dwell_q, err_dwell_d;
  logic [2:0]       first_err_q, first_err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [15:0]      cycles_q, cycles_d;

  logic [2:0]       ns_l, ew_l;
  logic             ns_oh, ew_oh;
  logic             dec_ok;
  logic [1:0]       dec_ph;
  logic             det_conflict, det_lamp, det_seq, det_dwell;
  logic [CNT_W-1:0] dwell_inc, dwell_start, req_cur;
  logic [2:0]       n_det;
  logic [8:0]       cnt_sum;

  function automatic logic [CNT_W-1:0] req_ticks(input logic [1:0] p);
    case (p)
      PH_NS_G: req_ticks = CNT_W'(NS_G_TICKS);
      PH_NS_Y: req_ticks = CNT_W'(NS_Y_TICKS);
      PH_EW_G: req_ticks = CNT_W'(EW_G_TICKS);
      default: req_ticks = CNT_W'(EW_Y_TICKS);
    endcase
  endfunction

  always_comb begin
    smp_lamps_d = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
    smp_tick_d  = tick;
    smp_vld_d   = 1'b1;
  end

  always_comb begin
    ns_l   = smp_lamps_q[5:3];
    ew_l   = smp_lamps_q[2:0];
    ns_oh  = $onehot(ns_l);
    ew_oh  = $onehot(ew_l);
    dec_ok = 1'b1;
    dec_ph = PH_NS_G;
    case (smp_lamps_q)
      6'b100_001: dec_ph = PH_NS_G;
      6'b010_001: dec_ph = PH_NS_Y;
      6'b001_100: dec_ph = PH_EW_G;
      6'b001_010: dec_ph = PH_EW_Y;
      default:    dec_ok = 1'b0;
    endcase
    det_conflict = smp_vld_q & ns_oh & ew_oh & ~ns_l[0] & ~ew_l[0];
    det_lamp     = smp_vld_q & ~(ns_oh & ew_oh);
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    dwell_d       = dwell_q;
    dflag_d       = dflag_q;
    cycles_d      = cycles_q;
    det_seq       = 1'b0;
    det_dwell     = 1'b0;
    phase_valid_d = smp_vld_q & dec_ok;
    req_cur       = req_ticks(phase_q);
    dwell_start   = {{(CNT_W-1){1'b0}}, smp_tick_q};
    dwell_inc     = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + dwell_start;

    // Invalid samples leave phase and dwell untouched.
    if (smp_vld_q && dec_ok) begin
      if (state_q == ST_INIT) begin
        state_d = ST_TRACK;
        phase_d = dec_ph;
        dwell_d = dwell_start;
        dflag_d = 1'b0;
        det_seq = (dec_ph != PH_NS_G);
      end else if (dec_ph == phase_q) begin
        dwell_d = dwell_inc;
        if (dwell_inc > req_cur && !dflag_q) begin
          det_dwell = 1'b1;
          dflag_d   = 1'b1;
        end
      end else if (dec_ph == phase_q + 2'd1) begin
        // An overstay already reported this visit is not reported again on exit.
        det_dwell = (dwell_q != req_cur) && !dflag_q;
        if (phase_q == PH_EW_Y) cycles_d = cycles_q + 16'd1;
        phase_d = dec_ph;
        dwell_d = dwell_start;
        dflag_d = 1'b0;
      end else begin
        det_seq = 1'b1;
        phase_d = dec_ph;
        dwell_d = dwell_start;
        dflag_d = 1'b0;
      end
    end
  end

  always_comb begin
    err_conflict_d = err_conflict_q | det_conflict;
    err_lamp_d     = err_lamp_q | det_lamp;
    err_seq_d      = err_seq_q | det_seq;
    err_dwell_d    = err_dwell_q | det_dwell;
    n_det          = {2'b00, det_conflict} + {2'b00, det_lamp}
                   + {2'b00, det_seq} + {2'b00, det_dwell};
    cnt_sum        = {1'b0, err_count_q} + {6'b000000, n_det};
    err_count_d    = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    first_err_d    = first_err_q;
    if (first_err_q == 3'd0) begin
      if (det_conflict)   first_err_d = 3'd1;
      else if (det_lamp)  first_err_d = 3'd2;
      else if (det_seq)   first_err_d = 3'd3;
      else if (det_dwell) first_err_d = 3'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_lamps_q    <= '0;
      smp_tick_q     <= 1'b0;
      smp_vld_q      <= 1'b0;
      state_q        <= ST_INIT;
      phase_q        <= PH_NS_G;
      dwell_q        <= '0;
      dflag_q        <= 1'b0;
      phase_valid_q  <= 1'b0;
      err_conflict_q <= 1'b0;
      err_lamp_q     <= 1'b0;
      err_seq_q      <= 1'b0;
      err_dwell_q    <= 1'b0;
      first_err_q    <= 3'd0;
      err_count_q    <= 8'd0;
      cycles_q       <= 16'd0;
    end else begin
      smp_lamps_q    <= smp_lamps_d;
      smp_tick_q     <= smp_tick_d;
      smp_vld_q      <= smp_vld_d;
      state_q        <= state_d;
      phase_q        <= phase_d;
      dwell_q        <= dwell_d;
      dflag_q        <= dflag_d;
      phase_valid_q  <= phase_valid_d;
      err_conflict_q <= err_conflict_d;
      err_lamp_q     <= err_lamp_d;
      err_seq_q      <= err_seq_d;
      err_dwell_q    <= err_dwell_d;
      first_err_q    <= first_err_d;
      err_count_q    <= err_count_d;
      cycles_q       <= cycles_d;
    end
  end

  assign phase        = phase_q;
  assign phase_valid  = phase_valid_q;
  assign err_conflict = err_conflict_q;
  assign err_lamp     = err_lamp_q;
  assign err_seq      = err_seq_q;
  assign err_dwell    = err_dwell_q;
  assign err_any      = err_conflict_q | err_lamp_q | err_seq_q | err_dwell_q;
  assign first_err    = first_err_q;
  assign err_count    = err_count_q;
  assign cycles_done  = cycles_q;

endmodule
